// File: rtl/dc_exp_unit.sv
// ---------------------------------------------------------------------------
// dc_exp_unit
//   Data-cache exception unit for the read-operands stage. Every qualifying
//   cycle one memory read and one memory write (first and last byte) are
//   checked against their segment limits and against a fully associative
//   TLB. At most one prioritised exception (rd_prot > rd_pf > wr_prot > wr_pf)
//   is captured and held until the exception controller acknowledges it.
//
// Configuration macro:
//   DC_EXP_FAULT_INFO_EN  defined   -> fault_addr / pf_err_code registered
//                         undefined -> fault_addr / pf_err_code tied to 0
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   v_in, stall_in, isr   stage valid, stage stalled, handler executing
//   rd_en, wr_en          instruction reads / writes memory
//   rd_addr, rd_addr_end  linear first/last byte of the read
//   wr_addr, wr_addr_end  linear first/last byte of the write
//   rd_off_end, rd_limit  segment offset of last read byte, read seg limit
//   wr_off_end, wr_limit  segment offset of last write byte, write seg limit
//   tlb_vpn               packed VPNs, entry i at [i*VPN_W +: VPN_W]
//   tlb_valid/pr/rw       per-entry valid, present, writable
//   exp_ack               controller consumed the pending exception
//   exp_valid             exception pending
//   dc_rd_exp, dc_wr_exp  cause is the read / the write
//   dc_prot_exp           protection (segment limit or read-only page)
//   dc_page_fault         page not present / not mapped
//   fault_addr            faulting linear address (CR2)
//   pf_err_code           {U/S, W/R, P}
// ---------------------------------------------------------------------------
module dc_exp_unit #(
  parameter int TLB_ENTRIES = 8,
  parameter int VPN_W       = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         v_in,
  input  logic                         stall_in,
  input  logic                         isr,
  input  logic                         rd_en,
  input  logic                         wr_en,
  input  logic [31:0]                  rd_addr,
  input  logic [31:0]                  rd_addr_end,
  input  logic [31:0]                  wr_addr,
  input  logic [31:0]                  wr_addr_end,
  input  logic [31:0]                  rd_off_end,
  input  logic [31:0]                  rd_limit,
  input  logic [31:0]                  wr_off_end,
  input  logic [31:0]                  wr_limit,
  input  logic [TLB_ENTRIES*VPN_W-1:0] tlb_vpn,
  input  logic [TLB_ENTRIES-1:0]       tlb_valid,
  input  logic [TLB_ENTRIES-1:0]       tlb_pr,
  input  logic [TLB_ENTRIES-1:0]       tlb_rw,
  input  logic                         exp_ack,
  output logic                         exp_valid,
  output logic                         dc_rd_exp,
  output logic                         dc_wr_exp,
  output logic                         dc_prot_exp,
  output logic                         dc_page_fault,
  output logic [31:0]                  fault_addr,
  output logic [2:0]                   pf_err_code
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t state_q, state_d;
  logic   rd_exp_q, rd_exp_d;
  logic   wr_exp_q, wr_exp_d;
  logic   prot_q, prot_d;
  logic   pf_q, pf_d;

  // Returns {hit, writable} for one linear address. Scanning from the top
  // index down lets the lowest matching index overwrite the result, so the
  // lowest index wins on a multi-hit. hit is the present bit of the winner.
  function automatic logic [1:0] tlb_lookup(input logic [31:0] addr);
    logic [1:0]       res;
    logic [VPN_W-1:0] vpn;
    res = 2'b00;
    vpn = VPN_W'(addr[31:12]);
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (tlb_valid[i] && (tlb_vpn[i*VPN_W +: VPN_W] == vpn))
        res = {tlb_pr[i], tlb_rw[i]};
    end
    return res;
  endfunction

  logic [1:0] rs_lk, re_lk, ws_lk, we_lk;
  logic       wr_ro, fire;
  logic       rd_prot, rd_pf, wr_prot, wr_pf;

  always_comb begin
    rs_lk   = tlb_lookup(rd_addr);
    re_lk   = tlb_lookup(rd_addr_end);
    ws_lk   = tlb_lookup(wr_addr);
    we_lk   = tlb_lookup(wr_addr_end);
    // Write to a present but read-only page at either end of the access.
    wr_ro   = (ws_lk[1] & ~ws_lk[0]) | (we_lk[1] & ~we_lk[0]);
    fire    = v_in & ~stall_in & ~isr & (state_q == IDLE);
    rd_prot = rd_en & (rd_off_end > rd_limit);
    rd_pf   = rd_en & ~(rs_lk[1] & re_lk[1]);
    wr_prot = wr_en & ((wr_off_end > wr_limit) | wr_ro);
    wr_pf   = wr_en & ~(ws_lk[1] & we_lk[1]);
  end

  // Next-state / capture logic. Holding in PEND ignores new checks; ack
  // clears outputs on the same edge that returns to IDLE.
  always_comb begin
    state_d  = state_q;
    rd_exp_d = rd_exp_q;
    wr_exp_d = wr_exp_q;
    prot_d   = prot_q;
    pf_d     = pf_q;
    case (state_q)
      IDLE: begin
        rd_exp_d = 1'b0;
        wr_exp_d = 1'b0;
        prot_d   = 1'b0;
        pf_d     = 1'b0;
        if (fire && (rd_prot || rd_pf || wr_prot || wr_pf)) begin
          state_d  = PEND;
          rd_exp_d = rd_prot | rd_pf;
          wr_exp_d = ~(rd_prot | rd_pf);
          prot_d   = rd_prot | (~rd_pf & wr_prot);
          pf_d     = ~rd_prot & (rd_pf | ~wr_prot);
        end
      end
      PEND: begin
        if (exp_ack) begin
          state_d  = IDLE;
          rd_exp_d = 1'b0;
          wr_exp_d = 1'b0;
          prot_d   = 1'b0;
          pf_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_exp_q <= 1'b0;
      wr_exp_q <= 1'b0;
      prot_q   <= 1'b0;
      pf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_exp_q <= rd_exp_d;
      wr_exp_q <= wr_exp_d;
      prot_q   <= prot_d;
      pf_q     <= pf_d;
    end
  end

  assign exp_valid     = (state_q == PEND);
  assign dc_rd_exp     = rd_exp_q;
  assign dc_wr_exp     = wr_exp_q;
  assign dc_prot_exp   = prot_q;
  assign dc_page_fault = pf_q;

`ifdef DC_EXP_FAULT_INFO_EN
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [2:0]  pf_err_code_q, pf_err_code_d;

  // For page faults the start address is reported if it missed; otherwise
  // the end access crossed into an unmapped page whose base is reported.
  always_comb begin
    fault_addr_d  = fault_addr_q;
    pf_err_code_d = pf_err_code_q;
    if (state_q == IDLE) begin
      fault_addr_d  = 32'h0;
      pf_err_code_d = 3'b000;
      if (fire) begin
        if (rd_prot) begin
          fault_addr_d = rd_addr;
        end else if (rd_pf) begin
          fault_addr_d = rs_lk[1] ? {rd_addr_end[31:12], 12'h000} : rd_addr;
        end else if (wr_prot) begin
          fault_addr_d  = wr_addr;
          pf_err_code_d = {2'b01, wr_ro};
        end else if (wr_pf) begin
          fault_addr_d  = ws_lk[1] ? {wr_addr_end[31:12], 12'h000} : wr_addr;
          pf_err_code_d = 3'b010;
        end
      end
    end else if (exp_ack) begin
      fault_addr_d  = 32'h0;
      pf_err_code_d = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_addr_q  <= 32'h0;
      pf_err_code_q <= 3'b000;
    end else begin
      fault_addr_q  <= fault_addr_d;
      pf_err_code_q <= pf_err_code_d;
    end
  end

  assign fault_addr  = fault_addr_q;
  assign pf_err_code = pf_err_code_q;
`else
  assign fault_addr  = 32'h0;
  assign pf_err_code = 3'b000;
`endif

endmodule

// File: tb/tb_dc_exp_unit.sv
// ---------------------------------------------------------------------------
// tb_dc_exp_unit
//   Directed and randomized stimulus for dc_exp_unit, compared every cycle
//   against a behavioural model of the exception rules. Honours
//   DC_EXP_FAULT_INFO_EN for the fault-info outputs.
// ---------------------------------------------------------------------------
module tb_dc_exp_unit;
  localparam int N = 8;
  localparam int VW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, v_in, stall_in, isr, rd_en, wr_en, exp_ack;
  logic [31:0]   rd_addr, rd_addr_end, wr_addr, wr_addr_end;
  logic [31:0]   rd_off_end, rd_limit, wr_off_end, wr_limit;
  logic [N*VW-1:0] tlb_vpn;
  logic [N-1:0]  tlb_valid, tlb_pr, tlb_rw;
  logic          exp_valid, dc_rd_exp, dc_wr_exp, dc_prot_exp, dc_page_fault;
  logic [31:0]   fault_addr;
  logic [2:0]    pf_err_code;

  logic [VW-1:0] vpn_a [N];

  always_comb begin
    tlb_vpn = '0;
    for (int i = 0; i < N; i++) tlb_vpn[i*VW +: VW] = vpn_a[i];
  end

  dc_exp_unit #(.TLB_ENTRIES(N), .VPN_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .v_in(v_in), .stall_in(stall_in), .isr(isr),
    .rd_en(rd_en), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_addr_end(rd_addr_end),
    .wr_addr(wr_addr), .wr_addr_end(wr_addr_end),
    .rd_off_end(rd_off_end), .rd_limit(rd_limit),
    .wr_off_end(wr_off_end), .wr_limit(wr_limit),
    .tlb_vpn(tlb_vpn), .tlb_valid(tlb_valid), .tlb_pr(tlb_pr), .tlb_rw(tlb_rw),
    .exp_ack(exp_ack), .exp_valid(exp_valid),
    .dc_rd_exp(dc_rd_exp), .dc_wr_exp(dc_wr_exp),
    .dc_prot_exp(dc_prot_exp), .dc_page_fault(dc_page_fault),
    .fault_addr(fault_addr), .pf_err_code(pf_err_code)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: what the unit should be presenting.
  bit          m_pend, m_rd, m_wr, m_prot, m_pf;
  logic [31:0] m_fa;
  logic [2:0]  m_ec;

  // Index of first valid entry mapping the page of a, or -1.
  function automatic int find_entry(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if (tlb_valid[i] && vpn_a[i] == a[31:12]) return i;
    return -1;
  endfunction

  function automatic bit page_ok(input logic [31:0] a);
    int e = find_entry(a);
    return (e >= 0) && tlb_pr[e];
  endfunction

  function automatic bit page_ro(input logic [31:0] a);
    int e = find_entry(a);
    return (e >= 0) && tlb_pr[e] && !tlb_rw[e];
  endfunction

  task automatic m_set(input bit r, input bit w, input bit p, input bit f,
                       input logic [31:0] fa, input logic [2:0] ec);
    m_pend = 1; m_rd = r; m_wr = w; m_prot = p; m_pf = f; m_fa = fa; m_ec = ec;
  endtask

  task automatic m_clr();
    m_pend = 0; m_rd = 0; m_wr = 0; m_prot = 0; m_pf = 0; m_fa = 0; m_ec = 0;
  endtask

  // Evaluates what the next clock edge should produce from current inputs.
  task automatic model_edge();
    bit wro;
    if (!rst_n) m_clr();
    else if (m_pend) begin
      if (exp_ack) m_clr();
    end else if (v_in && !stall_in && !isr) begin
      wro = page_ro(wr_addr) || page_ro(wr_addr_end);
      if (rd_en && rd_off_end > rd_limit)
        m_set(1, 0, 1, 0, rd_addr, 3'b000);
      else if (rd_en && !(page_ok(rd_addr) && page_ok(rd_addr_end)))
        m_set(1, 0, 0, 1, page_ok(rd_addr) ? {rd_addr_end[31:12], 12'h000} : rd_addr, 3'b000);
      else if (wr_en && (wr_off_end > wr_limit || wro))
        m_set(0, 1, 1, 0, wr_addr, {2'b01, wro});
      else if (wr_en && !(page_ok(wr_addr) && page_ok(wr_addr_end)))
        m_set(0, 1, 0, 1, page_ok(wr_addr) ? {wr_addr_end[31:12], 12'h000} : wr_addr, 3'b010);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] efa;
    logic [2:0]  eec;
`ifdef DC_EXP_FAULT_INFO_EN
    efa = m_fa; eec = m_ec;
`else
    efa = 32'h0; eec = 3'b000;
`endif
    chk({tag, ".exp_valid"}, 32'(exp_valid), 32'(m_pend));
    chk({tag, ".rd_exp"},    32'(dc_rd_exp), 32'(m_rd));
    chk({tag, ".wr_exp"},    32'(dc_wr_exp), 32'(m_wr));
    chk({tag, ".prot"},      32'(dc_prot_exp), 32'(m_prot));
    chk({tag, ".pf"},        32'(dc_page_fault), 32'(m_pf));
    chk({tag, ".fault_addr"}, fault_addr, efa);
    chk({tag, ".err_code"},  32'(pf_err_code), 32'(eec));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_in();
    v_in = 0; stall_in = 0; isr = 0; rd_en = 0; wr_en = 0; exp_ack = 0;
    rd_addr = 0; rd_addr_end = 0; wr_addr = 0; wr_addr_end = 0;
    rd_off_end = 0; rd_limit = 32'hFFFF_FFFF; wr_off_end = 0; wr_limit = 32'hFFFF_FFFF;
  endtask

  task automatic rd_pf_in();
    v_in = 1; rd_en = 1; wr_en = 0;
    rd_addr = 32'h0040_1FFE; rd_addr_end = 32'h0040_2001;
    rd_off_end = 32'h10; rd_limit = 32'hFFFF_FFFF;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [19:0] pages [5] = '{20'h00400, 20'h00401, 20'h00402, 20'h00410, 20'h00403};
    return {pages[$urandom_range(0, 4)], 12'($urandom)};
  endfunction

  initial begin
    m_clr();
    idle_in();
    rst_n = 0;
    for (int i = 0; i < N; i++) vpn_a[i] = 20'hFFFF0 + 20'(i);
    tlb_valid = '0; tlb_pr = '0; tlb_rw = '0;
    // Entry 3: 0x00400 rw; entry 1: 0x00401 rw; entry 6 duplicates 0x00400
    // but not present (lowest index must win); entry 5: 0x00410 read-only.
    vpn_a[3] = 20'h00400; tlb_valid[3] = 1; tlb_pr[3] = 1; tlb_rw[3] = 1;
    vpn_a[1] = 20'h00401; tlb_valid[1] = 1; tlb_pr[1] = 1; tlb_rw[1] = 1;
    vpn_a[6] = 20'h00400; tlb_valid[6] = 1; tlb_pr[6] = 0; tlb_rw[6] = 0;
    vpn_a[5] = 20'h00410; tlb_valid[5] = 1; tlb_pr[5] = 1; tlb_rw[5] = 0;
    step("reset0");
    step("reset1");
    rst_n = 1;

    // Mapped read inside limits: no exception.
    v_in = 1; rd_en = 1; rd_addr = 32'h0040_0010; rd_addr_end = 32'h0040_0013;
    rd_off_end = 32'h13; rd_limit = 32'hFFFF_FFFF;
    step("rd_ok");
    chk("rd_ok.direct_valid", 32'(exp_valid), 32'h0);

    // Read crossing into unmapped page 0x00402.
    rd_pf_in();
    step("rd_pf");
    chk("rd_pf.direct_flags", {28'h0, exp_valid, dc_rd_exp, dc_page_fault, dc_prot_exp}, 32'hE);
`ifdef DC_EXP_FAULT_INFO_EN
    chk("rd_pf.direct_fa", fault_addr, 32'h0040_2000);
`else
    chk("rd_pf.direct_fa", fault_addr, 32'h0);
`endif

    // Hold in PEND with new faulting inputs (a write to a read-only page).
    wr_en = 1; wr_addr = 32'h0410_0000; wr_addr_end = 32'h0041_0003;
    wr_addr = 32'h0041_0000; wr_off_end = 32'h3; wr_limit = 32'hFFFF_FFFF;
    step("hold1"); step("hold2"); step("hold3");
    // Ack with a simultaneous fault: ack wins, fault dropped.
    exp_ack = 1;
    step("ack_drop");
    exp_ack = 0; idle_in();
    step("idle_after_ack");

    // Write to read-only page plus read over segment limit: rd_prot wins.
    tlb_rw[3] = 0;
    v_in = 1; wr_en = 1; wr_addr = 32'h0040_0020; wr_addr_end = 32'h0040_0023;
    wr_off_end = 32'h23; wr_limit = 32'hFFFF_FFFF;
    rd_en = 1; rd_addr = 32'h0040_0100; rd_addr_end = 32'h0040_0103;
    rd_off_end = 32'h1001; rd_limit = 32'h1000;
    step("rd_prot_wins");
    chk("rd_prot_wins.direct", {28'h0, dc_rd_exp, dc_wr_exp, dc_prot_exp, dc_page_fault}, 32'hA);
    exp_ack = 1; rd_en = 0;
    step("ack1");
    // Write-only now: write-protection fault with P=1, W/R=1.
    exp_ack = 0;
    step("wr_prot");
    exp_ack = 1; step("ack2");
    exp_ack = 0; tlb_rw[3] = 1; idle_in();

    // Suppressed checks.
    rd_pf_in(); isr = 1;
    step("isr_suppress");
    isr = 0; stall_in = 1;
    step("stall_suppress");
    stall_in = 0; exp_ack = 1;     // ack ignored in IDLE, fault captured
    step("ack_in_idle");
    exp_ack = 0; isr = 1;          // isr in PEND does not clear
    step("isr_in_pend");
    isr = 0; rst_n = 0; exp_ack = 0;
    step("rst_in_pend");
    rst_n = 1; idle_in();
    step("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      v_in     = ($urandom_range(0, 9) != 0);
      stall_in = ($urandom_range(0, 7) == 0);
      isr      = ($urandom_range(0, 9) == 0);
      exp_ack  = ($urandom_range(0, 2) == 0);
      rst_n    = ($urandom_range(0, 49) != 0);
      rd_en    = $urandom_range(0, 1);
      wr_en    = $urandom_range(0, 1);
      rd_addr  = rnd_addr(); rd_addr_end = rd_addr + $urandom_range(0, 7);
      wr_addr  = rnd_addr(); wr_addr_end = wr_addr + $urandom_range(0, 7);
      rd_limit = 32'h1000 + $urandom_range(0, 15); rd_off_end = 32'h1000 + $urandom_range(0, 17);
      wr_limit = 32'h2000 + $urandom_range(0, 15); wr_off_end = 32'h2000 + $urandom_range(0, 17);
      if ($urandom_range(0, 9) == 0) begin
        tlb_pr[$urandom_range(0, N-1)] = $urandom_range(0, 1);
        tlb_rw[$urandom_range(0, N-1)] = $urandom_range(0, 1);
        tlb_valid[$urandom_range(0, N-1)] = $urandom_range(0, 1);
      end
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dc_exp_unit.md
# dc_exp_unit

Registered, parametrised data-cache exception unit for the read-operands stage. Each cycle it checks one memory read and one memory write (start and end addresses) against segment limits and a TLB of configurable depth. It raises at most one prioritised exception and holds it until the exception/ISR controller acknowledges it. It can optionally capture the x86-style faulting linear address and page-fault error code for the handler.

## Interface
- TLB_ENTRIES, 8, number of TLB entries searched; ≥1
- VPN_W, 20, virtual page number width; page size fixed at 4 KB
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- v_in  in  1  stage holds a valid instruction
- stall_in  in  1  stage stalled; no capture this cycle
- isr  in  1  handler executing; all checks suppressed
- rd_en / wr_en  in  1 each  instruction reads / writes memory
- rd_addr, rd_addr_end, wr_addr, wr_addr_end  in  32 each  linear first/last byte addresses
- rd_off_end, rd_limit, wr_off_end, wr_limit  in  32 each  segment offsets of last byte; segment limits
- tlb_vpn  in  TLB_ENTRIES*VPN_W  entry i at [i*VPN_W +: VPN_W]
- tlb_valid, tlb_pr, tlb_rw  in  TLB_ENTRIES each  valid, present, writable per entry
- exp_ack  in  1  controller has consumed the pending exception
- exp_valid  out  1  exception pending
- dc_rd_exp, dc_wr_exp, dc_prot_exp, dc_page_fault  out  1 each  cause flags, one-hot among {rd,wr} and among {prot,pf}
- fault_addr  out  32  faulting linear address (CR2 value)
- pf_err_code  out  3  {U/S=0, W/R, P}

## Operation
- Lookup for each of the 4 addresses: match VPN = addr[31:12] against all valid entries; lowest index wins on multi-hit. Hit = match & tlb_pr of the winning entry.
- Read checks (rd_en): rd_prot = rd_off_end > rd_limit (unsigned, 32-bit). rd_pf = start or end lookup not a hit.
- Write checks (wr_en): wr_prot = wr_off_end > wr_limit, or a start/end lookup hit whose tlb_rw=0. wr_pf = start or end lookup not a hit.
- A check fires only if v_in=1, stall_in=0, isr=0, and the unit is in IDLE.
- Priority, highest first: rd_prot, rd_pf, wr_prot, wr_pf. Only the winner is captured.
- fault_addr: for prot causes, the start address. For pf causes, the start address if the start lookup missed, else the end address with [11:0] cleared.
- pf_err_code: P=0 for a miss, P=1 for a write to a read-only page; W/R=1 for write causes; U/S=0.
- FSM:
  - IDLE: a firing check registers outputs -> PEND. Otherwise stay in IDLE with outputs 0.
  - PEND: outputs held constant and new checks ignored. exp_ack=1 -> IDLE, outputs cleared on the same edge.
- Reset: state IDLE; exp_valid, all cause flags, fault_addr and pf_err_code = 0.

## Timing
- Latency 1: the check result appears on the clock edge after the qualifying cycle.
- exp_ack is sampled only in PEND; it is ignored in IDLE.
- Ack and a new fault in the same cycle: the ack wins and the fault is dropped, because the pipeline is flushed. Back-to-back exceptions therefore have at least one IDLE cycle between them.
- Stall in IDLE: nothing captured, outputs stay 0. Stall in PEND: no effect.
- rst_n low in PEND: IDLE next edge, pending exception lost. rst_n overrides exp_ack.
- isr rising while in PEND does not clear the exception; only exp_ack or reset does.

## Configuration
- DC_EXP_FAULT_INFO_EN defined: fault_addr and pf_err_code are registered as above.
- DC_EXP_FAULT_INFO_EN undefined: fault_addr and pf_err_code are constant 0 and their registers and muxes are removed. Cause flags and FSM are unchanged.

## Test plan
- Entry 3 = VPN 0x00400, valid, pr, rw. Read of 0x00400010..0x00400013 with limit 0xFFFFFFFF -> exp_valid stays 0.
- Read 0x00401FFE..0x00402001, only VPN 0x00401 mapped -> next cycle exp_valid=1, dc_rd_exp=1, dc_page_fault=1, fault_addr=0x00402000, pf_err_code=3'b000.
- Write to a mapped page with rw=0 at 0x00400020, simultaneous read with rd_off_end=0x1001 > rd_limit=0x1000 -> dc_rd_exp=1, dc_prot_exp=1, fault_addr=rd_addr (rd_prot wins priority).
- Page fault pending, hold 3 cycles with new faulting inputs -> outputs unchanged. exp_ack=1 together with a new fault -> outputs 0 next cycle, state IDLE.
- Faulting access with isr=1 or stall_in=1 -> no exception. rst_n=0 in PEND -> all outputs 0 next edge.
- Build without DC_EXP_FAULT_INFO_EN, rerun the page-fault case -> cause flags as before, fault_addr=0, pf_err_code=0.
